muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int ITER = 32;

    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 multiply add-shift or restoring divide subtract-shift.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}
        sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        // Divide: acc = {remainder, dividend/quotient bits}; trial uses the shifted remainder
        trial = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (is_div) begin
            if (!trial[WIDTH])
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            else
                acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO.
// Define MULDIV_ZERO_SKIP_EN to bypass the iterations when b==0 at start.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import muldiv_pkg::*;

    localparam int W2 = 2 * WIDTH;

    state_t           state;
    logic [4:0]       cnt;
    logic             is_div_r;
    logic             neg_res;
    logic             neg_rem;
    logic             b_zero;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] operand;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    step_acc;

    logic             is_div_in;
    logic             signed_in;
    logic             skip;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic             fix_dz;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [W2-1:0] apply_sign_wide(input logic [W2-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        is_div_in = (op == OP_DIV) || (op == OP_DIVU);
        signed_in = (op == OP_MULT) || (op == OP_DIV);
        a_abs     = magnitude(a, signed_in);
        b_abs     = magnitude(b, signed_in);
`ifdef MULDIV_ZERO_SKIP_EN
        skip      = (b == '0);
`else
        skip      = 1'b0;
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_r),
        .acc_in  (acc),
        .operand (operand),
        .acc_out (step_acc)
    );

    // 0x80000000 / -1 needs no special case: magnitude 2^31 negates back to itself.
    always_comb begin
        fix_dz = 1'b0;
        fix_hi = '0;
        fix_lo = '0;
        if (!is_div_r) begin
            {fix_hi, fix_lo} = apply_sign_wide(acc, neg_res);
        end else if (b_zero) begin
            fix_hi = a_raw;
            fix_lo = DIV_ZERO_LO;
            fix_dz = 1'b1;
        end else begin
            fix_hi = apply_sign(acc[W2-1:WIDTH], neg_rem);
            fix_lo = apply_sign(acc[WIDTH-1:0], neg_res);
        end
    end

    // Working datapath registers: loaded at start, iterated in CALC, no reset needed.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            is_div_r <= is_div_in;
            neg_res  <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= signed_in & a[WIDTH-1];
            b_zero   <= (b == '0);
            a_raw    <= a;
            if (is_div_in) begin
                acc     <= {{WIDTH{1'b0}}, a_abs};
                operand <= b_abs;
            end else begin
                acc     <= {{WIDTH{1'b0}}, b_abs};
                operand <= a_abs;
            end
        end else if (state == S_CALC) begin
            acc <= step_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= skip ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == 5'(ITER - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    div_zero <= fix_dz;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    cnt      <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    // Edges after the start edge until done is visible
    localparam int FULL_LAT = 33;
`ifdef MULDIV_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and waits (bounded) for done; returns edges after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_multu;
        int lat, bc;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL multu_latency got %0d want %0d", lat, FULL_LAT); end
        checks++; if (bc !== FULL_LAT) begin errors++; $display("FAIL multu_busy_cycles got %0d want %0d", bc, FULL_LAT); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want %h", hi, 32'hFFFFFFFE); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want %h", lo, 32'h1); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL multu_div_zero got %b want 0", div_zero); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", done); end
    endtask

    task automatic test_mult;
        int lat, bc;
        run_op(MULT, 32'hFFFFFFFD, 32'd7, lat, bc);
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi got %h want %h", hi, 32'hFFFFFFFF); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo got %h want %h", lo, 32'hFFFFFFEB); end
        run_op(MULT, 32'h80000000, 32'h80000000, lat, bc);
        checks++; if (hi !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi got %h want %h", hi, 32'h40000000); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mult_min_lo got %h want %h", lo, 32'h0); end
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL mult_latency got %0d want %0d", lat, FULL_LAT); end
    endtask

    task automatic test_div;
        int lat, bc;
        run_op(DIV, 32'hFFFFFFF9, 32'd2, lat, bc);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want %h", lo, 32'hFFFFFFFD); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want %h", hi, 32'hFFFFFFFF); end
        run_op(DIV, 32'd7, 32'hFFFFFFFE, lat, bc);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdiv_lo got %h want %h", lo, 32'hFFFFFFFD); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL div_negdiv_hi got %h want %h", hi, 32'h1); end
        run_op(DIVU, 32'd7, 32'd2, lat, bc);
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want %h", lo, 32'd3); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want %h", hi, 32'd1); end
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL divu_latency got %0d want %0d", lat, FULL_LAT); end
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want %h", lo, 32'h80000000); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want %h", hi, 32'h0); end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        run_op(DIVU, 32'd5, 32'd0, lat, bc);
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo got %h want %h", lo, 32'hFFFFFFFF); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divu0_hi got %h want %h", hi, 32'd5); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divu0_flag got %b want 1", div_zero); end
        checks++; if (lat !== ZERO_LAT) begin errors++; $display("FAIL divu0_latency got %0d want %0d", lat, ZERO_LAT); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divu0_flag_held got %b want 1", div_zero); end
        run_op(DIV, 32'hFFFFFFF9, 32'd0, lat, bc);
        checks++; if (hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL div0_hi_raw got %h want %h", hi, 32'hFFFFFFF9); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got %h want %h", lo, 32'hFFFFFFFF); end
        run_op(MULT, 32'd3, 32'd4, lat, bc);
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL mult_clears_flag got %b want 0", div_zero); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL mult_small_lo got %h want %h", lo, 32'd12); end
        run_op(MULTU, 32'hDEADBEEF, 32'd0, lat, bc);
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL multu0_result got %h want %h", {hi, lo}, 64'h0); end
        checks++; if (lat !== ZERO_LAT) begin errors++; $display("FAIL multu0_latency got %0d want %0d", lat, ZERO_LAT); end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h00001234;
        @(negedge clk);
        hi_we = 1'b0;
        checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL mthi got %h want %h", hi, 32'h1234); end
        lo_we = 1'b1; wdata = 32'h00005678;
        @(negedge clk);
        lo_we = 1'b0;
        checks++; if (lo !== 32'h00005678) begin errors++; $display("FAIL mtlo got %h want %h", lo, 32'h5678); end
        checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL mtlo_keeps_hi got %h want %h", hi, 32'h1234); end
    endtask

    // Relies on hi/lo = 0x1234/0x5678 left by test_mthi_mtlo.
    task automatic test_busy_ignore;
        int lat, dcount;
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (10) begin @(posedge clk); #1; lat++; end
        checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL calc_hi_held got %h want %h", hi, 32'h1234); end
        checks++; if (lo !== 32'h00005678) begin errors++; $display("FAIL calc_lo_held got %h want %h", lo, 32'h5678); end
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADDEAD;
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        lat++;
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL busy_ignore_latency got %0d want %0d", lat, FULL_LAT); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL busy_ignore_hi got %h want %h", hi, 32'd0); end
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL busy_ignore_lo got %h want %h", lo, 32'd15); end
        dcount = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) dcount++; end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL busy_start_not_queued got %0d want 0", dcount); end
    endtask

    task automatic test_rst_mid;
        int lat, bc, dcount;
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo got %h want %h", {hi, lo}, 64'h0); end
        dcount = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) dcount++; end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", dcount); end
        run_op(DIVU, 32'd100, 32'd7, lat, bc);
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL rst_after_latency got %0d want %0d", lat, FULL_LAT); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL rst_after_lo got %h want %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL rst_after_hi got %h want %h", hi, 32'd2); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        run_op(MULTU, 32'd6, 32'd7, lat, bc);
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL b2b_first_lo got %h want %h", lo, 32'd42); end
        // done is high now, so the FSM is in IDLE and this start must be taken
        start = 1'b1; op = DIVU; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== FULL_LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, FULL_LAT); end
        checks++; if (lo !== 32'd4) begin errors++; $display("FAIL b2b_second_lo got %h want %h", lo, 32'd4); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_second_hi got %h want %h", hi, 32'd1); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_busy_ignore();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
